// File: rtl/stack_alu.sv
// stack_alu: RPN command sequencer mastering a lifo; tracks occupancy, flags under/overflow.
// Define STACK_ALU_SAT_EN for saturating ADD (all-ones) and SUB (clamp to 0).
module stack_alu #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         cmd_valid,
   output logic                         cmd_ready,
   input  logic [2:0]                   cmd_op,
   input  logic [WIDTH-1:0]             cmd_data,
   output logic                         stk_push,
   output logic                         stk_pop,
   output logic [WIDTH-1:0]             stk_data_in,
   input  logic [WIDTH-1:0]             stk_data_out,
   input  logic                         stk_empty,
   input  logic                         stk_full,
   output logic                         res_valid,
   output logic [WIDTH-1:0]             res_data,
   output logic                         err_underflow,
   output logic                         err_overflow,
   output logic [$clog2(DEPTH+1)-1:0]   count
);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
   localparam logic [CW-1:0] ONE_C = CW'(1);

   typedef enum logic [3:0] {IDLE, PUSH, POP_B, POP_A, CAP_A, WB, POP_O, CAP_O, CLR} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    count_q, count_d;
   logic [2:0]       op_q, op_d;
   logic [WIDTH-1:0] imm_q, imm_d, a_q, a_d, b_q, b_d, res_q, res_d;
   logic [WIDTH-1:0] add_r, sub_r, alu;
   logic             uf_q, uf_d, of_q, of_d, acc;

`ifdef STACK_ALU_SAT_EN
   logic [WIDTH:0] sum;
   assign sum   = {1'b0, a_q} + {1'b0, b_q};
   assign add_r = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
   assign sub_r = (a_q < b_q) ? '0 : a_q - b_q;
`else
   assign add_r = a_q + b_q;
   assign sub_r = a_q - b_q;
`endif

   assign alu = op_q == 3'b001 ? add_r :
                op_q == 3'b010 ? sub_r :
                op_q == 3'b011 ? a_q & b_q :
                op_q == 3'b100 ? a_q | b_q : a_q ^ b_q;

   assign cmd_ready     = state_q == IDLE && !rst;
   assign stk_push      = state_q == PUSH || state_q == WB;
   assign stk_pop       = state_q inside {POP_B, POP_A, POP_O, CLR};
   assign stk_data_in   = state_q == PUSH ? imm_q : state_q == WB ? alu : '0;
   assign res_valid     = state_q == CAP_O;
   assign res_data      = res_valid ? stk_data_out : res_q;
   assign err_underflow = uf_q;
   assign err_overflow  = of_q;
   assign count         = count_q;

   always_comb begin
      acc     = cmd_valid && cmd_ready;
      state_d = state_q;
      uf_d    = 1'b0;
      of_d    = 1'b0;
      op_d    = acc ? cmd_op : op_q;
      imm_d   = acc ? cmd_data : imm_q;
      b_d     = state_q == POP_A ? stk_data_out : b_q;
      a_d     = state_q == CAP_A ? stk_data_out : a_q;
      res_d   = state_q == CAP_O ? stk_data_out : res_q;
      count_d = stk_push ? count_q + ONE_C : stk_pop ? count_q - ONE_C : count_q;
      // Checks are decided at acceptance so the error pulse lands one cycle later
      case (state_q)
         IDLE: if (acc) begin
            if (cmd_op == 3'b000) begin
               of_d    = count_q == FULL_C || stk_full;
               state_d = of_d ? IDLE : PUSH;
            end else if (cmd_op == 3'b110) begin
               uf_d    = count_q == '0 || stk_empty;
               state_d = uf_d ? IDLE : POP_O;
            end else if (cmd_op == 3'b111) begin
               state_d = count_q == '0 ? IDLE : CLR;
            end else begin
               uf_d    = count_q <= ONE_C;
               state_d = uf_d ? IDLE : POP_B;
            end
         end
         POP_B:   state_d = POP_A;
         POP_A:   state_d = CAP_A;
         CAP_A:   state_d = WB;
         POP_O:   state_d = CAP_O;
         CLR:     state_d = count_q == ONE_C ? IDLE : CLR;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         count_q <= '0;
         op_q    <= '0;
         imm_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         uf_q    <= 1'b0;
         of_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         op_q    <= op_d;
         imm_q   <= imm_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         uf_q    <= uf_d;
         of_q    <= of_d;
      end
   end
endmodule

// File: tb/tb_stack_alu.sv
// tb_stack_alu: scoreboard bench for stack_alu with a behavioural lifo attached.
module tb_stack_alu;
   logic        clk = 1'b0, rst, cmd_valid, cmd_ready;
   logic [2:0]  cmd_op;
   logic [15:0] cmd_data, stk_data_in, stk_data_out, res_data;
   logic        stk_push, stk_pop, stk_empty, stk_full, res_valid, err_underflow, err_overflow;
   logic [2:0]  count;

   int          n_chk = 0, n_err = 0, n_push = 0, n_pop = 0;
   logic [15:0] model[$];
   logic [15:0] res_exp[$];
   int          err_exp[$];
   logic [15:0] exp_din = '0;

   logic [15:0] mem[0:3];
   int          sp;

   always #5 clk = ~clk;

   stack_alu #(.WIDTH(16), .DEPTH(4)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_data(cmd_data), .stk_push(stk_push), .stk_pop(stk_pop), .stk_data_in(stk_data_in),
      .stk_data_out(stk_data_out), .stk_empty(stk_empty), .stk_full(stk_full),
      .res_valid(res_valid), .res_data(res_data), .err_underflow(err_underflow),
      .err_overflow(err_overflow), .count(count)
   );

   always @(posedge clk) begin
      if (rst) begin
         sp <= 0;
         stk_data_out <= '0;
      end else if (stk_push && sp < 4) begin
         mem[sp] <= stk_data_in;
         sp <= sp + 1;
      end else if (stk_pop && sp > 0) begin
         stk_data_out <= mem[sp-1];
         sp <= sp - 1;
      end
   end
   assign stk_empty = sp == 0;
   assign stk_full  = sp == 4;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] alu(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
      logic [16:0] s;
      s = {1'b0, a} + {1'b0, b};
      case (op)
`ifdef STACK_ALU_SAT_EN
         3'd1: alu = s[16] ? 16'hFFFF : s[15:0];
         3'd2: alu = a < b ? 16'h0000 : a - b;
`else
         3'd1: alu = s[15:0];
         3'd2: alu = a - b;
`endif
         3'd3: alu = a & b;
         3'd4: alu = a | b;
         default: alu = a ^ b;
      endcase
   endfunction

   always @(negedge clk) begin
      if (!rst) begin
         if (stk_push || stk_pop) chk("push_pop_excl", {31'b0, stk_push && stk_pop}, 0);
         if (stk_push) begin
            n_push++;
            chk("din", stk_data_in, exp_din);
         end
         if (stk_pop) n_pop++;
         if (res_valid) begin
            if (res_exp.size() > 0) chk("res", res_data, res_exp.pop_front());
            else chk("res_unexp", res_valid, 0);
         end
         if (err_underflow || err_overflow)
            chk("err", {30'b0, err_overflow, err_underflow}, err_exp.size() > 0 ? err_exp.pop_front() : 0);
      end
   end

   task automatic do_cmd(input logic [2:0] op, input logic [15:0] d);
      int lat, exp_lat, exp_push, exp_pop, p0, q0;
      logic [15:0] a, b;
      exp_push = 0; exp_pop = 0; exp_lat = 1;
      case (op)
         3'd0: if (model.size() == 4) err_exp.push_back(2);
               else begin model.push_back(d); exp_din = d; exp_push = 1; exp_lat = 2; end
         3'd6: if (model.size() == 0) err_exp.push_back(1);
               else begin res_exp.push_back(model.pop_back()); exp_pop = 1; exp_lat = 3; end
         3'd7: begin exp_pop = model.size(); exp_lat = exp_pop == 0 ? 1 : exp_pop + 1; model.delete(); end
         default: if (model.size() < 2) err_exp.push_back(1);
                  else begin
                     b = model.pop_back(); a = model.pop_back();
                     exp_din = alu(op, a, b); model.push_back(exp_din);
                     exp_pop = 2; exp_push = 1; exp_lat = 5;
                  end
      endcase
      p0 = n_push; q0 = n_pop;
      @(negedge clk);
      chk("ready_pre", {31'b0, cmd_ready}, 1);
      cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
      @(posedge clk);
      #1 cmd_valid = 1'b0; cmd_op = 3'($urandom); cmd_data = 16'($urandom);
      lat = 0;
      do begin @(negedge clk); lat++; end while (!cmd_ready && lat < 40);
      #1;
      chk("latency", lat, exp_lat);
      chk("count", {29'b0, count}, model.size());
      chk("n_push", n_push - p0, exp_push);
      chk("n_pop", n_pop - q0, exp_pop);
      chk("err_pending", err_exp.size(), 0);
      chk("res_pending", res_exp.size(), 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", {31'b0, cmd_ready}, 0);
      chk("rst_count", {29'b0, count}, 0);
      chk("rst_strobes", {28'b0, stk_push, stk_pop, res_valid, err_underflow | err_overflow}, 0);
      chk("rst_res_data", res_data, 0);
      chk("rst_din", stk_data_in, 0);
      rst = 1'b0;
      model.delete();
      #1 chk("ready_after_rst", {31'b0, cmd_ready}, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0] op;
      int r;
      rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0;
      do_reset();
      do_cmd(3'd0, 16'h0003); do_cmd(3'd0, 16'h0005); do_cmd(3'd1, '0); do_cmd(3'd6, '0);
      do_cmd(3'd0, 16'h0002); do_cmd(3'd0, 16'h0007); do_cmd(3'd2, '0); do_cmd(3'd6, '0);
      for (int i = 1; i <= 5; i++) do_cmd(3'd0, 16'(i));
      do_reset();
      do_cmd(3'd0, 16'h00F0); do_cmd(3'd5, '0); do_cmd(3'd6, '0); do_cmd(3'd6, '0);
      repeat (3) do_cmd(3'd0, 16'hFFFF);
      do_cmd(3'd7, '0);
      chk("empty_after_clear", {31'b0, stk_empty}, 1);
      do_cmd(3'd7, '0);
      do_cmd(3'd0, 16'hFFFF); do_cmd(3'd0, 16'h0002); do_cmd(3'd1, '0);
      do_cmd(3'd0, 16'h3C3C); do_cmd(3'd4, '0); do_cmd(3'd0, 16'h0FF0); do_cmd(3'd3, '0);
      do_cmd(3'd6, '0);
      for (int i = 0; i < 40; i++) begin
         r  = $urandom_range(0, 9);
         op = r < 4 ? 3'd0 : r == 9 ? ($urandom_range(0, 3) == 0 ? 3'd7 : 3'd6) : 3'(r - 3);
         do_cmd(op, 16'($urandom));
      end
      do_cmd(3'd7, '0);
      // Reset landing in POP_A of an AND
      do_cmd(3'd0, 16'hA5A5); do_cmd(3'd0, 16'h0F0F);
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 3'd3; cmd_data = '0;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("in_pop_a", {31'b0, stk_pop}, 1);
      rst = 1'b1;
      #1 chk("ready_in_rst", {31'b0, cmd_ready}, 0);
      @(negedge clk);
      chk("mid_rst_strobes", {28'b0, stk_push, stk_pop, res_valid, err_underflow | err_overflow}, 0);
      chk("mid_rst_count", {29'b0, count}, 0);
      chk("mid_rst_empty", {31'b0, stk_empty}, 1);
      rst = 1'b0;
      model.delete();
      #1 chk("ready_post_rst", {31'b0, cmd_ready}, 1);
      do_cmd(3'd6, '0);
      do_cmd(3'd0, 16'h1234); do_cmd(3'd6, '0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
